// File: rtl/series_sum_engine.sv
// rtl/series_sum_engine.sv - Multi-mode series accumulator: sum of term(i) for i = N down to 1, one term per clock.
// Ready/valid in on the operand, valid/ready out on the result, sticky overflow and illegal-mode flag.
module series_sum_engine #(
  parameter int N_WIDTH   = 8,
  parameter int SUM_WIDTH = 24
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [N_WIDTH-1:0]   N,
  input  logic [1:0]           Mode,
  input  logic                 N_valid,
  output logic                 N_ready,
  output logic [SUM_WIDTH-1:0] Sum,
  output logic                 Sum_valid,
  input  logic                 Sum_ready,
  output logic                 Overflow,
  output logic                 Mode_err,
  output logic                 Busy
);

  // Terms are formed wide enough for both the square and the result before truncation.
  localparam int TW = (2 * N_WIDTH > SUM_WIDTH) ? 2 * N_WIDTH : SUM_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state;
  logic [N_WIDTH-1:0]   i;
  logic [1:0]           mode_q;
  logic [SUM_WIDTH-1:0] sum_q;
  logic                 ovf_q;
  logic                 merr_q;

  logic [2*N_WIDTH-1:0] square;
  logic [TW-1:0]        term_wide;
  logic                 term_trunc;
  logic [SUM_WIDTH:0]   add_full;

  assign square = {{N_WIDTH{1'b0}}, i} * {{N_WIDTH{1'b0}}, i};

  always_comb begin
    term_wide = '0;
    case (mode_q)
      2'b00:   term_wide = TW'(i);
      2'b01:   term_wide = TW'(square);
      2'b10:   term_wide = (TW'(i) << 1) - TW'(1);
      default: term_wide = '0;
    endcase
  end

  // Any term bit above the result width is lost, so it counts as overflow.
  assign term_trunc = |(term_wide >> SUM_WIDTH);
  assign add_full   = {1'b0, sum_q} + {1'b0, term_wide[SUM_WIDTH-1:0]};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      i      <= '0;
      mode_q <= 2'b00;
      sum_q  <= '0;
      ovf_q  <= 1'b0;
      merr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (N_valid) begin
            mode_q <= Mode;
            i      <= N;
            sum_q  <= '0;
            ovf_q  <= 1'b0;
            merr_q <= 1'b0;
            if (Mode == 2'b11) begin
              merr_q <= 1'b1;
              state  <= DONE;
            end else if (N == '0) begin
              state  <= DONE;
            end else begin
              state  <= BUSY;
            end
          end
        end
        BUSY: begin
          sum_q <= add_full[SUM_WIDTH-1:0];
          ovf_q <= ovf_q | add_full[SUM_WIDTH] | term_trunc;
          i     <= i - 1'b1;
          if (i == N_WIDTH'(1)) state <= DONE;
        end
        DONE: begin
          if (Sum_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign N_ready   = (state == IDLE);
  assign Busy      = (state == BUSY);
  assign Sum_valid = (state == DONE);
  assign Sum       = sum_q;
  assign Overflow  = ovf_q;
  assign Mode_err  = merr_q;

endmodule

// File: doc/series_sum_engine.md
# series_sum_engine

Parametrised multi-mode series accumulator that computes sums over i = N down to 1, one term per clock. It has an input ready/valid handshake on the operand and an output valid/ready handshake on the result. It sits in the arithmetic datapath as a drop-in successor to the fixed 8-bit natural-number summer. It adds configurable widths, three series modes, output back-pressure, overflow reporting and defined N = 0 behaviour.

## Interface

Parameters:
- N_WIDTH, 8: operand width.
- SUM_WIDTH, 24: result width. Must be ≥ N_WIDTH + 1.

Ports:
- Clk, input, 1: clock; all state updates on the rising edge.
- Rst, input, 1: reset, synchronous, active-high.
- N, input, N_WIDTH: upper bound of the series (unsigned).
- Mode, input, 2: series select. 00 = Σi; 01 = Σi²; 10 = Σ(2i−1); 11 = illegal.
- N_valid, input, 1: operand valid.
- N_ready, output, 1: block can accept an operand (state IDLE).
- Sum, output, SUM_WIDTH: result; meaningful only while Sum_valid = 1.
- Sum_valid, output, 1: result valid (state DONE).
- Sum_ready, input, 1: downstream accepts the result.
- Overflow, output, 1: result wrapped modulo 2^SUM_WIDTH; qualified by Sum_valid.
- Mode_err, output, 1: operand was issued with Mode = 11; qualified by Sum_valid.
- Busy, output, 1: state BUSY.

## Operation

- FSM has three states: IDLE (00), BUSY (01), DONE (10). Encoding 11 is unreachable; if entered, next state is IDLE.
- Outputs are decoded from state: N_ready = IDLE; Busy = BUSY; Sum_valid = DONE.
- **IDLE.** An accept occurs on N_valid & N_ready. On accept:
  - Latch Mode, load i ← N, clear Sum, Overflow and Mode_err.
  - Mode = 11: set Mode_err, go to DONE with Sum = 0.
  - N = 0: go to DONE with Sum = 0, Overflow = 0.
  - Otherwise go to BUSY.
- **BUSY.** Each cycle:
  - Sum ← Sum + term(i) and i ← i − 1.
  - When i == 1, that cycle's add is the last one and next state is DONE.
  - N_valid is ignored.
- **Term computation.**
  - Mode 00: term = i.
  - Mode 01: term = i·i, computed at 2·N_WIDTH bits.
  - Mode 10: term = 2i − 1.
  - Terms are zero-extended, or truncated, to SUM_WIDTH.
  - Overflow becomes sticky-set if the SUM_WIDTH + 1 bit add carries out, or if any truncated term bit is nonzero.
  - Sum wraps modulo 2^SUM_WIDTH.
- **DONE.**
  - Sum, Overflow and Mode_err hold stable until Sum_valid & Sum_ready, then next state is IDLE.
  - N_valid is ignored in DONE; the new operand is accepted only once back in IDLE.
- **Reset.** Rst has priority over every other condition in any state, including mid-BUSY and during DONE. The operation in progress is discarded with no result produced.

## Timing

- Reset values, visible after the first Rst edge:
  - State = IDLE, N_ready = 1, Busy = 0, Sum_valid = 0.
  - Sum = 0, Overflow = 0, Mode_err = 0, i = 0.
- Call the accept edge edge 0.
- N ≥ 1, legal Mode:
  - BUSY is occupied for exactly N cycles; the add for term N happens at edge 1 and for term 1 at edge N.
  - Sum_valid is first high in the cycle after edge N.
- N = 0 or Mode = 11: Sum_valid is high in the cycle after edge 0.
- Result handshake:
  - With Sum_ready held high, DONE lasts one cycle and N_ready returns after edge N + 1.
  - Minimum issue interval is N + 2 cycles.
- Back-pressure: DONE persists indefinitely while Sum_ready = 0, with outputs frozen.
- Sum_ready is sampled only in DONE and ignored elsewhere.
- Widths: i is N_WIDTH bits. Default widths cover Mode 01 at N = 255 (5 559 680 < 2^24) without overflow.

## Test plan

- **Linear.** Rst for 2 cycles, then N = 10, Mode 00, Sum_ready = 1 → Sum = 55, Sum_valid first high 10 cycles after accept, Overflow = 0. Repeat with N = 255 → 32 640.
- **Square and odd.** N = 10, Mode 01 → 385. N = 10, Mode 10 → 100. N = 255, Mode 01 → 5 559 680, Overflow = 0.
- **Degenerate operands.**
  - N = 0, Mode 00 → Sum = 0, Sum_valid in the cycle after accept.
  - N = 1 → Sum = 1 after 1 BUSY cycle.
  - Mode = 11, N = 7 → Sum = 0, Mode_err = 1, no BUSY cycles.
- **Overflow.** SUM_WIDTH = 9, N_WIDTH = 8, N = 40, Mode 00 → true sum 820. Required: Sum = 820 mod 512 = 308, Overflow = 1, cleared on next accept.
- **Back-pressure.**
  - N = 5, Sum_ready = 0 for 6 cycles after Sum_valid → Sum = 15 held stable, N_ready = 0.
  - N_valid with N = 3 asserted throughout DONE is not accepted until IDLE, then yields 6.
- **Reset mid-operation.** N = 200, Mode 00, Rst asserted on the 50th BUSY cycle → next cycle shows all reset values, N_ready = 1, no Sum_valid pulse. A following N = 4 → 10.
